// File: rtl/mp_arb_pkg.sv
// mp_arb_pkg: shared types, constants and round-robin pick helper for mp_arbiter
package mp_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;
  localparam int OPC_W = 4;
  localparam int MAX_CORES = 8;
  localparam int BCNT_W = 4;
  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } rr_pick_t;
  function automatic rr_pick_t rr_pick(input logic [MAX_CORES-1:0] req, input logic [2:0] ptr, input int n);
    rr_pick_t p;
    int j;
    p = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % n;
      if (i < n && req[j[2:0]]) begin
        p.any = 1'b1;
        p.idx = j[2:0];
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/mp_rd_tag_pipe.sv
// mp_rd_tag_pipe: read-tag delay line and tagged return-data register
module mp_rd_tag_pipe #(
  parameter int IW = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tag_valid,
  input  logic [IW-1:0]         tag_id,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [IW-1:0]         core_id_out
);
  logic [IW:0] pipe [RD_LATENCY];
  logic hit;
  assign hit = s_rvalid && pipe[RD_LATENCY-1][IW];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      rvalid <= 1'b0;
      data_out <= '0;
      core_id_out <= '0;
    end else begin
      pipe[0] <= {tag_valid, tag_id};
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      rvalid <= hit;
      if (hit) begin
        data_out <= s_data;
        core_id_out <= pipe[RD_LATENCY-1][IW-1:0];
      end
    end
  end
endmodule

// File: rtl/mp_arbiter.sv
// mp_arbiter: round-robin burst arbiter for a shared resource; define MP_ARB_BURST_EN for multi-beat bursts
module mp_arbiter
  import mp_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4,
  parameter int RD_LATENCY = 1,
  localparam int IW = $clog2(NUM_CORES)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES*OPC_W-1:0]      core_opcode,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_A,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_B,
  input  logic [NUM_CORES-1:0]            core_we,
  input  logic [NUM_CORES-1:0]            core_read_en,
  output logic [NUM_CORES-1:0]            gnt,
  output logic                            m_valid,
  output logic [OPC_W-1:0]                m_opcode,
  output logic [ADDR_WIDTH-1:0]           m_addr,
  output logic [DATA_WIDTH-1:0]           m_A,
  output logic [DATA_WIDTH-1:0]           m_B,
  output logic                            m_we,
  output logic                            m_read_en,
  output logic [IW-1:0]                   m_core_id,
  input  logic                            s_rvalid,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            rvalid,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [IW-1:0]                   core_id_out,
  output logic [31:0]                     burst_id
);
  if (NUM_CORES < 2 || NUM_CORES > MAX_CORES || (NUM_CORES & (NUM_CORES - 1)) != 0) begin : g_bad_cores
    $error("NUM_CORES must be a power of two in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
    $error("MAX_BURST must be in 1..16");
  end
  if (RD_LATENCY < 1) begin : g_bad_lat
    $error("RD_LATENCY must be at least 1");
  end
  arb_state_t state;
  logic [IW-1:0] rr_ptr, win;
  rr_pick_t pick;
  logic beat, last, done, unused_pick;
  assign pick = rr_pick(8'(req), 3'(rr_ptr), NUM_CORES);
  assign unused_pick = ^pick;
  assign beat = state == BUSY && req[win];
  assign done = state == BUSY && (!req[win] || last);
`ifdef MP_ARB_BURST_EN
  logic [BCNT_W-1:0] beat_cnt;
  assign last = beat_cnt == BCNT_W'(MAX_BURST - 1);
  always_ff @(posedge clk) begin
    if (!reset_n || state != BUSY) beat_cnt <= '0;
    else if (beat) beat_cnt <= beat_cnt + BCNT_W'(1);
  end
`else
  assign last = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= '0;
      win <= '0;
      burst_id <= '0;
      m_valid <= 1'b0;
      m_opcode <= '0;
      m_addr <= '0;
      m_A <= '0;
      m_B <= '0;
      m_we <= 1'b0;
      m_read_en <= 1'b0;
      m_core_id <= '0;
    end else begin
      m_valid <= beat;
      if (beat) begin
        m_opcode <= core_opcode[win*OPC_W +: OPC_W];
        m_addr <= core_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        m_A <= core_A[win*DATA_WIDTH +: DATA_WIDTH];
        m_B <= core_B[win*DATA_WIDTH +: DATA_WIDTH];
        m_we <= core_we[win];
        m_read_en <= core_read_en[win] && !core_we[win];
        m_core_id <= win;
      end
      if (state == IDLE && pick.any) begin
        state <= BUSY;
        gnt <= NUM_CORES'(1) << pick.idx;
        win <= pick.idx[IW-1:0];
        burst_id <= burst_id + 32'd1;
      end
      if (done) begin
        state <= GAP;
        gnt <= '0;
        rr_ptr <= win + IW'(1);
      end
      if (state == GAP) state <= IDLE;
    end
  end
  mp_rd_tag_pipe #(
    .IW(IW),
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk(clk),
    .reset_n(reset_n),
    .tag_valid(m_valid && m_read_en),
    .tag_id(m_core_id),
    .s_rvalid(s_rvalid),
    .s_data(s_data),
    .rvalid(rvalid),
    .data_out(data_out),
    .core_id_out(core_id_out)
  );
endmodule

// File: tb/tb_mp_arbiter.sv
// tb_mp_arbiter: table, directed and random checks of mp_arbiter against a transaction-level model
module tb_mp_arbiter;
  localparam int C = 4, AW = 11, DW = 8, MB = 4, RL = 1, IW = 2, NC = 8192;
`ifdef MP_ARB_BURST_EN
  localparam int BL = MB;
`else
  localparam int BL = 1;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic [C-1:0] req, core_we, core_read_en, gnt;
  logic [C*4-1:0] core_opcode;
  logic [C*AW-1:0] core_addr;
  logic [C*DW-1:0] core_A, core_B;
  logic m_valid, m_we, m_read_en, s_rvalid, rvalid;
  logic [3:0] m_opcode;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_A, m_B, s_data, data_out;
  logic [IW-1:0] m_core_id, core_id_out;
  logic [31:0] burst_id;

  mp_arbiter #(.NUM_CORES(C), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .RD_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .core_opcode(core_opcode), .core_addr(core_addr),
    .core_A(core_A), .core_B(core_B), .core_we(core_we), .core_read_en(core_read_en), .gnt(gnt),
    .m_valid(m_valid), .m_opcode(m_opcode), .m_addr(m_addr), .m_A(m_A), .m_B(m_B), .m_we(m_we),
    .m_read_en(m_read_en), .m_core_id(m_core_id), .s_rvalid(s_rvalid), .s_data(s_data),
    .rvalid(rvalid), .data_out(data_out), .core_id_out(core_id_out), .burst_id(burst_id)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int own = -1, ptr = 0, nb = 0, free_at = 0, last_rst = 0;
  int rd_at [NC];
  int spur = 1;
  logic force_a5 = 1'b0;
  logic [C-1:0] x_gnt;
  logic x_mv, x_we, x_rd, x_rv;
  logic [31:0] x_bid;
  logic [3:0] x_op;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_a, x_b, x_dout;
  logic [IW-1:0] x_id, x_cid;

  typedef struct {
    logic [C-1:0] req;
    logic [C-1:0] gnt;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: owner/beat count plus the earliest edge a new grant may be issued.
  task automatic model_step();
    int e;
    if (!reset_n) begin
      own = -1; ptr = 0; free_at = cyc + 1; last_rst = cyc;
      x_gnt = '0; x_mv = 0; x_bid = '0; x_op = '0; x_addr = '0; x_a = '0; x_b = '0;
      x_we = 0; x_rd = 0; x_id = '0; x_rv = 0; x_dout = '0; x_cid = '0;
    end else begin
      e = cyc - RL - 1;
      x_rv = s_rvalid && e > last_rst && rd_at[e] >= 0;
      if (x_rv) begin
        x_dout = s_data;
        x_cid = IW'(rd_at[e]);
      end
      x_mv = 0;
      if (own >= 0) begin
        if (req[own]) begin
          x_mv = 1; x_id = IW'(own);
          x_op = core_opcode[own*4 +: 4];
          x_addr = core_addr[own*AW +: AW];
          x_a = core_A[own*DW +: DW];
          x_b = core_B[own*DW +: DW];
          x_we = core_we[own];
          x_rd = core_read_en[own] && !core_we[own];
          if (x_rd) rd_at[cyc] = own;
          nb++;
        end
        if (!req[own] || nb == BL) begin
          ptr = (own + 1) % C; own = -1; free_at = cyc + 2;
        end
      end else if (cyc >= free_at && req != '0) begin
        for (int k = C - 1; k >= 0; k--) if (req[(ptr + k) % C]) own = (ptr + k) % C;
        nb = 0; x_bid = x_bid + 1;
      end
      x_gnt = '0;
      if (own >= 0) x_gnt[own] = 1'b1;
    end
  endtask

  task automatic tick();
    int idx;
    @(posedge clk);
    cyc++;
    #1;
    model_step();
    chk("gnt", gnt, x_gnt); chk("m_valid", m_valid, x_mv); chk("burst_id", burst_id, x_bid);
    chk("m_core_id", m_core_id, x_id); chk("m_opcode", m_opcode, x_op); chk("m_addr", m_addr, x_addr);
    chk("m_A", m_A, x_a); chk("m_B", m_B, x_b); chk("m_we", m_we, x_we); chk("m_read_en", m_read_en, x_rd);
    chk("rvalid", rvalid, x_rv); chk("data_out", data_out, x_dout); chk("core_id_out", core_id_out, x_cid);
    idx = cyc - RL;
    if (idx >= 0 && rd_at[idx] >= 0) begin
      s_rvalid = 1'b1;
      s_data = force_a5 ? 8'hA5 : DW'($urandom);
    end else begin
      s_rvalid = spur == 2 || (spur == 1 && $urandom_range(0, 5) == 0);
      s_data = DW'($urandom);
    end
  endtask

  task automatic set_core(input int c, input logic [3:0] op, input logic [AW-1:0] ad,
                          input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic w, input logic r);
    core_opcode[c*4 +: 4] = op; core_addr[c*AW +: AW] = ad;
    core_A[c*DW +: DW] = av; core_B[c*DW +: DW] = bv;
    core_we[c] = w; core_read_en[c] = r;
  endtask

  task automatic wait_gnt(input logic [C-1:0] want, output int at);
    logic [C-1:0] pg;
    at = -1;
    for (int n = 0; n < 64 && at < 0; n++) begin
      pg = gnt;
      tick();
      if (gnt == want && pg != want) at = cyc;
    end
    chk("wait_gnt", at >= 0, 1);
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    req = '0; reset_n = 1'b0; tick(); reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, t2, t3, t4;
    for (int i = 0; i < NC; i++) rd_at[i] = -1;
    req = '0; core_opcode = '0; core_addr = '0; core_A = '0; core_B = '0;
    core_we = '0; core_read_en = '0; s_rvalid = 0; s_data = '0;
    tbl = '{'{4'b0100, 4'b0100}, '{4'b0011, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b0010, 4'b0010},
            '{4'b1001, 4'b1000}, '{4'b1000, 4'b1000}, '{4'b0110, 4'b0010}, '{4'b0101, 4'b0100},
            '{4'b0001, 4'b0001}, '{4'b1100, 4'b0100}};
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    chk("rst_gnt", gnt, 0); chk("rst_mv", m_valid, 0); chk("rst_bid", burst_id, 0); chk("rst_rv", rvalid, 0);
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      tick();
      chk("tbl_gnt", gnt, tbl[i].gnt);
      chk("tbl_bid", burst_id, i + 1);
      idle(3);
    end
    // single core burst with stepping addresses
    do_reset();
    set_core(2, 4'h3, 11'h010, 8'h11, 8'h22, 0, 0);
    req = 4'b0100;
    tick(); chk("sc_gnt", gnt, 4'b0100); chk("sc_bid", burst_id, 1);
    tick(); chk("sc_mv", m_valid, 1); chk("sc_addr", m_addr, 11'h010); chk("sc_id", m_core_id, 2);
    set_core(2, 4'h3, 11'h011, 8'h11, 8'h22, 0, 0); tick();
    set_core(2, 4'h3, 11'h012, 8'h11, 8'h22, 0, 0); tick();
    idle(4);
    // all cores requesting: strict rotation
    do_reset();
    for (int c = 0; c < C; c++) set_core(c, 4'(c), AW'(c * 3), DW'(c), DW'(c + 8), 0, 0);
    req = 4'b1111;
    wait_gnt(4'b0001, t0); wait_gnt(4'b0010, t1); wait_gnt(4'b0100, t2);
    wait_gnt(4'b1000, t3); wait_gnt(4'b0001, t4);
    chk("rot_gap01", t1 - t0, BL + 2); chk("rot_gap12", t2 - t1, BL + 2);
    chk("rot_gap23", t3 - t2, BL + 2); chk("rot_gap30", t4 - t3, BL + 2);
    idle(BL + 3);
    // read return tagging
    set_core(1, 4'h5, 11'h7FF, 8'h00, 8'h00, 0, 1);
    force_a5 = 1'b1;
    req = 4'b0010;
    tick(); tick();
    chk("rd_beat", m_read_en, 1);
    req = '0;
    for (int k = 0; k < RL; k++) tick();
    tick();
    chk("rd_rvalid", rvalid, 1); chk("rd_data", data_out, 8'hA5); chk("rd_id", core_id_out, 1);
    force_a5 = 1'b0;
    idle(3);
    // write/read conflict with s_rvalid held high
    set_core(0, 4'h9, 11'h123, 8'h44, 8'h55, 1, 1);
    spur = 2;
    req = 4'b0001;
    tick(); tick();
    chk("wr_we", m_we, 1); chk("wr_rd", m_read_en, 0);
    req = '0;
    for (int k = 0; k < RL + 3; k++) begin
      tick();
      chk("wr_norv", rvalid, 0);
    end
    spur = 1;
    // reset during core 3's burst
    set_core(3, 4'hC, 11'h300, 8'h33, 8'h77, 0, 1);
    req = 4'b1000;
    tick(); tick();
    reset_n = 1'b0; tick();
    chk("mr_gnt", gnt, 0); chk("mr_mv", m_valid, 0); chk("mr_bid", burst_id, 0);
    reset_n = 1'b1;
    req = 4'b1001;
    tick(); chk("mr_first", gnt, 4'b0001);
    idle(BL + 3);
    // single requester re-grant spacing
    req = 4'b0001;
    wait_gnt(4'b0001, t0); wait_gnt(4'b0001, t1); wait_gnt(4'b0001, t2);
    chk("rg_gap1", t1 - t0, BL + 2); chk("rg_gap2", t2 - t1, BL + 2);
    idle(BL + 3);
    // random traffic
    for (int n = 0; n < 2500; n++) begin
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(0, 3) == 0) req[c] = ~req[c];
        set_core(c, 4'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
      end
      reset_n = $urandom_range(0, 399) != 0;
      tick();
    end
    reset_n = 1'b1;
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
